// File: rtl/sbox_layer_serial.sv
// sbox_layer_serial: serial Spongent sBoxLayer, one byte (two nibbles) per cycle, streams byte index, done pulse.
// Optional lCounter injection at start is compiled in with SBOX_LAYER_LCOUNTER_EN.
module sbox_layer_serial #(
  parameter int NSBOX   = 33,
  parameter int STATE_W = 264,
  parameter int LC_W    = 8,
  parameter int IDX_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  input  logic [LC_W-1:0]    lc_in,
  output logic               busy,
  output logic               byte_valid,
  output logic [IDX_W-1:0]   byte_idx,
  output logic               done,
  output logic [STATE_W-1:0] state_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  // nibble x maps to SBOX[4x+3:4x]
  localparam logic [63:0] SBOX = 64'h63C958A7F4120BDE;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSBOX - 1);
`ifdef SBOX_LAYER_LCOUNTER_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return {SBOX[{b[7:4], 2'b00} +: 4], SBOX[{b[3:0], 2'b00} +: 4]};
  endfunction
  state_e               fsm_q, fsm_d;
  logic [STATE_W-1:0]   work_q, work_d, state_out_q, state_out_d, inj;
  logic [IDX_W-1:0]     cnt_q, cnt_d, byte_idx_q, byte_idx_d;
  logic                 busy_q, busy_d, done_q, done_d, byte_valid_q, byte_valid_d;
  logic [LC_W-1:0]      lc_rev;
  assign lc_rev = {<<{lc_in}};
  assign inj = LC_EN ? {lc_rev, {(STATE_W - 2*LC_W){1'b0}}, lc_in} : '0;
  always_comb begin
    fsm_d        = fsm_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    byte_valid_d = 1'b0;
    byte_idx_d   = byte_idx_q;
    state_out_d  = state_out_q;
    case (fsm_q)
      IDLE: if (start) begin
        work_d = state_in ^ inj;
        cnt_d  = '0;
        busy_d = 1'b1;
        fsm_d  = RUN;
      end
      RUN: begin
        work_d[{cnt_q, 3'b000} +: 8] = sub_byte(work_q[{cnt_q, 3'b000} +: 8]);
        byte_valid_d = 1'b1;
        byte_idx_d   = cnt_q;
        cnt_d        = (cnt_q == LAST) ? cnt_q : cnt_q + IDX_W'(1);
        fsm_d        = (cnt_q == LAST) ? DONE : RUN;
      end
      DONE: begin
        state_out_d = work_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        fsm_d       = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= IDLE;
      work_q       <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_idx_q   <= '0;
      state_out_q  <= '0;
    end else begin
      fsm_q        <= fsm_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      byte_valid_q <= byte_valid_d;
      byte_idx_q   <= byte_idx_d;
      state_out_q  <= state_out_d;
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign byte_valid = byte_valid_q;
  assign byte_idx   = byte_idx_q;
  assign state_out  = state_out_q;
endmodule

// File: tb/tb_sbox_layer_serial.sv
// tb_sbox_layer_serial: scoreboard bench for sbox_layer_serial; expected states queued at start, popped on done.
module tb_sbox_layer_serial;
  localparam int NSBOX = 33;
  localparam int LAT   = NSBOX + 1;
`ifdef SBOX_LAYER_LCOUNTER_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif
  logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [263:0] state_in = '0;
  logic [7:0]   lc_in = '0;
  logic         busy, byte_valid, done;
  logic [5:0]   byte_idx;
  logic [263:0] state_out;
  int checks = 0, errors = 0, cyc = 0, exp_idx = 0, t_start = 0, done_cnt = 0;
  logic         prev_busy = 1'b0;
  logic [263:0] sb_q[$];
  logic [263:0] last_exp = '0;
  logic [3:0]   sb [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                            4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};
  sbox_layer_serial dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in), .lc_in(lc_in),
    .busy(busy), .byte_valid(byte_valid), .byte_idx(byte_idx), .done(done), .state_out(state_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [263:0] model(input logic [263:0] s, input logic [7:0] lc);
    logic [263:0] r;
    logic [7:0] b;
    r = s;
    if (LC_EN) begin
      r[7:0] = r[7:0] ^ lc;
      for (int i = 0; i < 8; i++) r[263-i] = r[263-i] ^ lc[i];
    end
    for (int i = 0; i < NSBOX; i++) begin
      b = r[8*i +: 8];
      r[8*i +: 8] = {sb[b[7:4]], sb[b[3:0]]};
    end
    return r;
  endfunction
  function automatic logic [263:0] rnd264();
    logic [263:0] r;
    for (int i = 0; i < 9; i++) r[32*i +: 32] = (i == 8) ? {24'b0, 8'($urandom)} : $urandom;
    return r;
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic kick(input logic [263:0] s, input logic [7:0] lc, input bit accept);
    state_in = s;
    lc_in = lc;
    start = 1'b1;
    if (accept) begin
      last_exp = model(s, lc);
      sb_q.push_back(last_exp);
    end
    tick();
    start = 1'b0;
    state_in = rnd264();
    lc_in = 8'($urandom);
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 80) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        exp_idx = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy && !prev_busy) t_start = cyc;
        if (byte_valid) begin
          check("byte_idx", byte_idx, exp_idx);
          exp_idx++;
        end
        if (done) begin
          done_cnt++;
          check("valid_count", exp_idx, NSBOX);
          check("latency", cyc - t_start, LAT);
          check("done_flags", {busy, byte_valid}, 0);
          if (sb_q.size() == 0) check("unexpected_done", 1, 0);
          else check("state_out", state_out, sb_q.pop_front());
          exp_idx = 0;
        end
        prev_busy = busy;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [263:0] ramp;
    int d0, n;
    tick(3);
    check("rst_flags", {busy, done, byte_valid, byte_idx}, 0);
    check("rst_out", state_out, 0);
    rst = 1'b1;
    tick(2);
    kick('0, 8'h00, 1);
    wait_done();
    check("zero_state", state_out, {33{8'hEE}});
    tick(2);
    for (int i = 0; i < NSBOX; i++) ramp[8*i +: 8] = 8'(i);
    kick(ramp, 8'h00, 1);
    wait_done();
    check("ramp_b0", state_out[7:0], 8'hEE);
    check("ramp_b1", state_out[15:8], 8'hED);
    check("ramp_b16", state_out[135:128], 8'hDE);
    check("ramp_b32", state_out[263:256], 8'hBE);
    tick(2);
    kick('0, 8'h05, 1);
    wait_done();
    if (LC_EN) check("lc_state", state_out, {8'h8E, {31{8'hEE}}, 8'hE1});
    else check("lc_ignored", state_out, {33{8'hEE}});
    tick(2);
    d0 = done_cnt;
    kick(rnd264(), 8'($urandom), 1);
    tick(8);
    kick(rnd264(), 8'($urandom), 0);
    wait_done();
    kick(rnd264(), 8'($urandom), 1);
    check("single_done", done_cnt - d0, 1);
    wait_done();
    tick();
    check("b2b_done", done_cnt - d0, 2);
    tick(2);
    kick(rnd264(), 8'($urandom), 1);
    n = 0;
    while (!(byte_valid && byte_idx == 6'd12) && n < 40) begin
      tick();
      n++;
    end
    check("reach_idx12", {byte_valid, byte_idx}, {1'b1, 6'd12});
    #2 rst = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_flags", {busy, done, byte_valid}, 0);
    check("midrst_out", state_out, 0);
    tick(3);
    rst = 1'b1;
    d0 = done_cnt;
    tick(50);
    check("no_done_after_rst", done_cnt - d0, 0);
    kick(rnd264(), 8'($urandom), 1);
    wait_done();
    tick();
    for (int i = 0; i < 100; i++) begin
      state_in = rnd264();
      lc_in = 8'($urandom);
      tick();
      check("hold", state_out, last_exp);
    end
    check("queue_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
